// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared frame constants, tx state encoding and frame checksum helper
package uart_pkg;

    localparam logic [7:0] FRAME_HEAD  = 8'h55;
    localparam logic [7:0] FRAME_TAIL  = 8'hAA;
    localparam logic [7:0] FUNC_HS_PWM = 8'h01;
    localparam logic [7:0] FUNC_LS_PWM = 8'h02;
    localparam int         DATA_NUM    = 14;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP,
        TX_NEXT,
        TX_DONE
    } tx_state_t;

    // Modulo-256 sum of func and the first ten payload bytes (frame bytes 1..11).
    function automatic logic [7:0] frame_chksum(input logic [7:0] func, input logic [87:0] payload);
        logic [7:0] sum;
        sum = func;
        for (int i = 1; i < 11; i++) begin
            sum = sum + payload[8*i +: 8];
        end
        return sum;
    endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// rtl/uart_byte_tx.sv - 8N1 byte serialiser with bit-period counter and load/done handshake
module uart_byte_tx
    import uart_pkg::*;
#(
    parameter int BPS_CNT = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_load,
    input  logic [7:0] i_data,
    output logic       o_txd,
    output logic       o_done
);

    tx_state_t   r_state;
    logic [15:0] r_clk_cnt;
    logic [2:0]  r_bit_cnt;
    logic [7:0]  r_shift;
    logic        w_bit_end;

    assign w_bit_end = (r_clk_cnt == 16'(BPS_CNT - 1));
    // Asserted in the last clock of a stop bit so the next byte can follow with no gap.
    assign o_done    = (r_state == TX_STOP) && w_bit_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= TX_IDLE;
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            o_txd     <= 1'b1;
        end else begin
            if (r_state == TX_IDLE || w_bit_end) begin
                r_clk_cnt <= '0;
            end else begin
                r_clk_cnt <= r_clk_cnt + 16'd1;
            end
            case (r_state)
                TX_IDLE: begin
                    if (i_load) begin
                        r_state <= TX_START;
                        r_shift <= i_data;
                        o_txd   <= 1'b0;
                    end
                end
                TX_START: begin
                    if (w_bit_end) begin
                        r_state   <= TX_DATA;
                        r_bit_cnt <= '0;
                        o_txd     <= r_shift[0];
                    end
                end
                TX_DATA: begin
                    if (w_bit_end) begin
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= TX_STOP;
                            o_txd   <= 1'b1;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            r_shift   <= r_shift >> 1;
                            o_txd     <= r_shift[1];
                        end
                    end
                end
                TX_STOP: begin
                    if (w_bit_end) begin
                        if (i_load) begin
                            r_state <= TX_START;
                            r_shift <= i_data;
                            o_txd   <= 1'b0;
                        end else begin
                            r_state <= TX_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= TX_IDLE;
                    o_txd   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_mult_byte_tx.sv
// rtl/uart_mult_byte_tx.sv - 14-byte frame transmitter; UART_TX_CHKSUM_EN replaces byte 12 with a checksum
module uart_mult_byte_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int UART_BPS = 115200
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        send_req,
    input  logic [7:0]  func,
    input  logic [87:0] payload,
    output logic        uart_txd,
    output logic        tx_busy,
    output logic [7:0]  byte_cnt,
    output logic        pack_done
);

    localparam int         BPS_CNT  = CLK_FREQ / UART_BPS;
    localparam logic [7:0] LAST_IDX = 8'(DATA_NUM - 1);

    tx_state_t  r_state;
    logic       r_load;
    logic [7:0] r_pack [DATA_NUM];
    logic       w_accept;
    logic       w_tx_done;
    logic       w_load;
    logic [3:0] w_idx;
    logic [7:0] w_tx_data;

    assign w_accept  = (r_state == TX_IDLE) && send_req;
    assign w_load    = r_load || (w_tx_done && byte_cnt != LAST_IDX);
    assign w_idx     = (r_load || byte_cnt == LAST_IDX) ? 4'd0 : 4'(byte_cnt + 8'd1);
    assign w_tx_data = r_pack[w_idx];

    // Frame is snapshotted at accept so later input changes cannot disturb it.
    always_ff @(posedge sys_clk) begin
        if (w_accept) begin
            r_pack[0] <= FRAME_HEAD;
            r_pack[1] <= func;
            for (int i = 0; i < 10; i++) begin
                r_pack[2 + i] <= payload[87 - 8*i -: 8];
            end
`ifdef UART_TX_CHKSUM_EN
            r_pack[12] <= frame_chksum(func, payload);
`else
            r_pack[12] <= payload[7:0];
`endif
            r_pack[13] <= FRAME_TAIL;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state   <= TX_IDLE;
            r_load    <= 1'b0;
            tx_busy   <= 1'b0;
            byte_cnt  <= '0;
            pack_done <= 1'b0;
        end else begin
            case (r_state)
                TX_IDLE: begin
                    pack_done <= 1'b0;
                    if (send_req) begin
                        r_state  <= TX_START;
                        r_load   <= 1'b1;
                        tx_busy  <= 1'b1;
                        byte_cnt <= '0;
                    end
                end
                TX_START: begin
                    r_load  <= 1'b0;
                    r_state <= TX_DATA;
                end
                TX_DATA: begin
                    if (w_tx_done) begin
                        if (byte_cnt == LAST_IDX) begin
                            r_state   <= TX_DONE;
                            pack_done <= 1'b1;
                            tx_busy   <= 1'b0;
                            byte_cnt  <= '0;
                        end else begin
                            byte_cnt <= byte_cnt + 8'd1;
                        end
                    end
                end
                TX_DONE: begin
                    pack_done <= 1'b0;
                    r_state   <= TX_IDLE;
                end
                default: begin
                    r_state   <= TX_IDLE;
                    r_load    <= 1'b0;
                    tx_busy   <= 1'b0;
                    byte_cnt  <= '0;
                    pack_done <= 1'b0;
                end
            endcase
        end
    end

    uart_byte_tx #(
        .BPS_CNT (BPS_CNT)
    ) u_byte_tx (
        .clk    (sys_clk),
        .rst_n  (sys_rst_n),
        .i_load (w_load),
        .i_data (w_tx_data),
        .o_txd  (uart_txd),
        .o_done (w_tx_done)
    );

endmodule
